ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_keyboard_rx.sv | 127 ++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the keyboard bus, deserialises 11-bit frames,
// checks framing and odd parity, and queues good bytes in a small valid/ready FIFO.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);

  // Odd parity holds when the data bits plus the parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic          r_clk_meta, r_clk_sync, r_clk_prev;
  logic          r_dat_meta, r_dat_sync;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [IW-1:0] r_idle;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          r_frame_err, r_overflow;

  logic          w_fall;
  logic [10:0]   w_frame;
  logic          w_done, w_good, w_push_req, w_bad;
  logic          w_empty, w_full, w_pop, w_push, w_ovf_set;

  // The 11th bit is taken straight from the synchroniser so the frame completes on its own fall.
  assign w_fall     = r_clk_prev & ~r_clk_sync;
  assign w_frame    = {r_dat_sync, r_shift};
  assign w_done     = w_fall & (r_bit_cnt == 4'd10);
  assign w_good     = ~w_frame[0] & w_frame[10] & odd_parity_ok(w_frame[9:1]);
  assign w_push_req = w_done & w_good;
  assign w_bad      = w_done & ~w_good;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) & (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop      = ~w_empty & data_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;

  assign data       = r_mem[r_rd_ptr[AW-1:0]];
  assign data_valid = ~w_empty;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

  // Bus synchronisers, idle-high out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  // Deserialiser with idle watchdog that abandons a stalled partial frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= 4'd0;
      r_shift   <= 10'd0;
      r_idle    <= '0;
    end else if (w_fall) begin
      r_shift   <= w_frame[10:1];
      r_idle    <= '0;
      r_bit_cnt <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
    end else if (r_bit_cnt != 4'd0) begin
      if (r_idle == IW'(TIMEOUT)) begin
        r_bit_cnt <= 4'd0;
        r_idle    <= '0;
      end else begin
        r_idle    <= r_idle + {{(IW-1){1'b0}}, 1'b1};
      end
    end else begin
      r_idle <= '0;
    end
  end

  // Byte FIFO; a push into a full FIFO is accepted only when a pop frees the head slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= w_frame[8:1];
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Status flags: single-cycle framing error pulse and sticky overflow where set beats clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (w_ovf_set)    r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
      else              r_overflow <= r_overflow;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, queued expected bytes,
// and an independent monitor that checks every accepted byte and frame_err pulse.
module tb_ps2_keyboard_rx;

  localparam int TIMEOUT = 50000;
  localparam int H       = 5;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, data_ready, ovf_clr;
  logic [7:0] data;
  logic       data_valid, frame_err, overflow;

  int         n_vec = 0;
  int         n_err = 0;
  int         err_seen = 0;
  logic       prev_fe = 1'b0;
  logic [7:0] exp_q [$];

  ps2_keyboard_rx #(.FIFO_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  // mode 1: check data_valid latency on the last fall; mode 2: pulse data_ready on the push cycle
  task automatic send_bits(input logic [10:0] f, input int nbits, input int mode);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cycles(H);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        step(); step();
        check("latency_k1", {31'd0, data_valid}, 32'd0);
        step();
        check("latency_k2", {31'd0, data_valid}, 32'd1);
        wait_cycles(H - 3);
      end else if (i == 10 && mode == 2) begin
        step(); step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        wait_cycles(H - 3);
      end else begin
        wait_cycles(H);
      end
      ps2_clk = 1'b1;
    end
    wait_cycles(H);
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    data_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    wait_cycles(2);
    check("drain_queue_empty", exp_q.size(), 32'd0);
    check("drain_valid_low", {31'd0, data_valid}, 32'd0);
  endtask

  // Monitor: every accepted byte is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) begin
        err_seen++;
        n_vec++;
        if (prev_fe) begin
          n_err++;
          $display("FAIL frame_err_width: got 2+ cycles expected 1");
        end
      end
      prev_fe = frame_err;
      if (data_valid && data_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %0h expected none", data);
        end else begin
          automatic logic [7:0] e = exp_q.pop_front();
          if (data !== e) begin
            n_err++;
            $display("FAIL pop_data: got %0h expected %0h", data, e);
          end
        end
      end
    end else begin
      prev_fe = 1'b0;
    end
  end

  initial begin
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; data_ready = 1'b0; ovf_clr = 1'b0;
    wait_cycles(3);
    check("reset_valid", {31'd0, data_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_data", {24'd0, data}, 32'h0);
    rst = 1'b1;
    wait_cycles(3);

    // Basic frame with latency check, then pop
    exp_q.push_back(8'h1C);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, 1);
    check("basic_data", {24'd0, data}, 32'h1C);
    drain();

    // Bad parity, then bad stop bit
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, 0);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11, 0);
    wait_cycles(4);
    check("frame_err_count", err_seen, 32'd2);
    check("bad_frames_no_data", {31'd0, data_valid}, 32'd0);

    // Overflow with data_ready held low
    data_ready = 1'b0;
    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) exp_q.push_back(8'(v));
      send_bits(mk(8'(v), 1'b0, 1'b1), 11, 0);
      if (v == 8) check("full_no_overflow", {31'd0, overflow}, 32'd0);
    end
    wait_cycles(4);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    drain();
    check("overflow_sticky", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("overflow_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO push coinciding with a pop
    data_ready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      exp_q.push_back(8'(v));
      send_bits(mk(8'(v), 1'b0, 1'b1), 11, 0);
    end
    exp_q.push_back(8'h2A);
    send_bits(mk(8'h2A, 1'b0, 1'b1), 11, 2);
    wait_cycles(2);
    check("push_pop_full_no_overflow", {31'd0, overflow}, 32'd0);
    drain();

    // Partial frame abandoned by the idle timeout
    send_bits(mk(8'h33, 1'b0, 1'b1), 5, 0);
    wait_cycles(TIMEOUT + 10);
    exp_q.push_back(8'hF0);
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, 0);
    drain();
    check("timeout_no_frame_err", err_seen, 32'd2);

    // Asynchronous reset mid-frame with bytes buffered
    data_ready = 1'b0;
    send_bits(mk(8'h11, 1'b0, 1'b1), 11, 0);
    send_bits(mk(8'h22, 1'b0, 1'b1), 11, 0);
    send_bits(mk(8'h33, 1'b0, 1'b1), 11, 0);
    check("buffered_before_reset", {31'd0, data_valid}, 32'd1);
    send_bits(mk(8'h44, 1'b0, 1'b1), 4, 0);
    rst = 1'b0;
    #1;
    check("reset_mid_valid", {31'd0, data_valid}, 32'd0);
    check("reset_mid_overflow", {31'd0, overflow}, 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    exp_q.push_back(8'h5A);
    send_bits(mk(8'h5A, 1'b0, 1'b1), 11, 0);
    drain();
    check("final_frame_err_count", err_seen, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
